// File: rtl/tap_collector_pkg.sv
// Shared constants and types for the tap result collector: frame header,
// tap byte width and serializer state encoding.
package tap_collector_pkg;

  localparam int TAP_W = 8;
  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/tap_fifo.sv
// Synchronous FIFO holding captured tap sets; the head entry is always visible
// on dout. Push while full is ignored, and full is judged before any same-cycle pop.
module tap_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Read and write pointer update.
  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/tap_result_collector.sv
// Captures each new tap set reported by the search stage, restarts the search,
// and streams stored tap sets as A5-headed byte frames over valid/ready.
module tap_result_collector
  import tap_collector_pkg::*;
#(
  parameter int NUM_OF_TAPS = 6,
  parameter int SIZE        = 16,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     found,
  input  logic                     started,
  input  logic [NUM_OF_TAPS*8-1:0] co_buf,
  output logic                     search_res,
  output logic [7:0]               dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [7:0]               drop_cnt,
  output logic [15:0]              found_cnt
);

  localparam int W  = NUM_OF_TAPS * TAP_W;
  localparam int IW = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_OF_TAPS - 1);
  localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SIZE < 1) begin : g_bad_params
    $error("tap_result_collector: DEPTH must be a power of two >= 2");
  end

  logic         found_q_r;
  logic         capture_s;
  logic         push_s;
  logic         pop_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  logic [W-1:0] fifo_head_s;
  logic         accept_s;

  logic         search_res_r;
  logic [7:0]   drop_cnt_r;
  logic [15:0]  found_cnt_r;

  ser_state_t   state_r, state_nx_s;
  logic [IW-1:0] idx_r, idx_nx_s;
  logic [W-1:0] shreg_r, shreg_nx_s;
  logic [7:0]   dout_r, dout_nx_s;
  logic         dout_valid_r, dout_valid_nx_s;

  function automatic logic [7:0] tap_byte(input logic [W-1:0] v, input logic [IW-1:0] i);
    return v[i*TAP_W +: TAP_W];
  endfunction

  assign capture_s = found & ~found_q_r & started;
  assign push_s    = capture_s & ~fifo_full_s;
  assign accept_s  = dout_valid_r & dout_ready;

  tap_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push_s),
    .din   (co_buf),
    .pop   (pop_s),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Edge detector, restart pulse and event counters.
  always_ff @(posedge clk) begin
    if (res) begin
      found_q_r    <= 1'b0;
      search_res_r <= 1'b0;
      found_cnt_r  <= 16'h0000;
      drop_cnt_r   <= 8'h00;
    end else begin
      found_q_r    <= found;
      search_res_r <= capture_s;
      if (capture_s) begin
        found_cnt_r <= found_cnt_r + 16'd1;
        if (fifo_full_s && (drop_cnt_r != 8'hFF)) begin
          drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
          drop_cnt_r <= drop_cnt_r;
        end
      end
    end
  end

  // Serializer next-state; output byte and valid are computed one cycle ahead.
  always_comb begin
    state_nx_s      = state_r;
    idx_nx_s        = idx_r;
    shreg_nx_s      = shreg_r;
    dout_nx_s       = dout_r;
    dout_valid_nx_s = dout_valid_r;
    pop_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s           = 1'b1;
          shreg_nx_s      = fifo_head_s;
          idx_nx_s        = IDX_LAST;
          state_nx_s      = HEADER;
          dout_nx_s       = FRAME_HDR;
          dout_valid_nx_s = 1'b1;
        end else begin
          dout_nx_s       = 8'h00;
          dout_valid_nx_s = 1'b0;
        end
      end
      HEADER: begin
        if (accept_s) begin
          state_nx_s = DATA;
          dout_nx_s  = tap_byte(shreg_r, idx_r);
        end else begin
          dout_valid_nx_s = 1'b1;
        end
      end
      DATA: begin
        if (accept_s) begin
          if (idx_r == IDX_ZERO) begin
            state_nx_s      = IDLE;
            dout_nx_s       = 8'h00;
            dout_valid_nx_s = 1'b0;
          end else begin
            idx_nx_s  = idx_r - IDX_ONE;
            dout_nx_s = tap_byte(shreg_r, idx_r - IDX_ONE);
          end
        end else begin
          dout_valid_nx_s = 1'b1;
        end
      end
      default: begin
        state_nx_s      = IDLE;
        dout_nx_s       = 8'h00;
        dout_valid_nx_s = 1'b0;
      end
    endcase
  end

  // Serializer state and registered output stage.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r      <= IDLE;
      idx_r        <= IDX_ZERO;
      shreg_r      <= {W{1'b0}};
      dout_r       <= 8'h00;
      dout_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      idx_r        <= idx_nx_s;
      shreg_r      <= shreg_nx_s;
      dout_r       <= dout_nx_s;
      dout_valid_r <= dout_valid_nx_s;
    end
  end

  assign search_res = search_res_r;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign drop_cnt   = drop_cnt_r;
  assign found_cnt  = found_cnt_r;

endmodule

// File: tb/tb_tap_result_collector.sv
// Randomized scoreboard bench for tap_result_collector: a transaction-level model
// predicts frames, drops, counters and restart pulses; a monitor compares them.
module tb_tap_result_collector;
  import tap_collector_pkg::*;

  localparam int NT = 6;
  localparam int DEPTH = 8;
  localparam int W = NT * 8;

  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic         found = 1'b0;
  logic         started = 1'b0;
  logic [W-1:0] co_buf = '0;
  logic         dout_ready = 1'b0;
  logic         search_res;
  logic [7:0]   dout;
  logic         dout_valid;
  logic [7:0]   drop_cnt;
  logic [15:0]  found_cnt;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;
  int acc_total = 0;

  // reference model state
  logic [7:0]  exp_q[$];
  int          fifo_cnt_m = 0;
  bit          busy_m = 1'b0;
  bit          found_prev_m = 1'b0;
  bit          sr_m = 1'b0;
  bit          last_flag = 1'b0;
  logic [15:0] found_cnt_m = 16'h0000;
  logic [7:0]  drop_m = 8'h00;

  tap_result_collector #(
    .NUM_OF_TAPS (NT),
    .SIZE        (16),
    .DEPTH       (DEPTH)
  ) dut (
    .clk        (clk),
    .res        (res),
    .found      (found),
    .started    (started),
    .co_buf     (co_buf),
    .search_res (search_res),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .drop_cnt   (drop_cnt),
    .found_cnt  (found_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [W-1:0] d, input int hold);
    co_buf = d;
    found = 1'b1;
    tick(hold);
    found = 1'b0;
    tick(1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    ready_mode = 1;
    while ((exp_q.size() != 0 || busy_m || fifo_cnt_m != 0) && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  function automatic logic [W-1:0] rand_taps();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Model: capture rule, FIFO occupancy, serializer busy, counters.
  initial forever begin
    bit cap;
    bit full_b;
    @(posedge clk);
    if (res) begin
      fifo_cnt_m = 0; busy_m = 1'b0; found_prev_m = 1'b0; sr_m = 1'b0;
      last_flag = 1'b0; found_cnt_m = 16'h0000; drop_m = 8'h00;
      exp_q.delete();
    end else begin
      cap = found && !found_prev_m && started;
      found_prev_m = found;
      full_b = (fifo_cnt_m == DEPTH);
      if (!busy_m && fifo_cnt_m > 0) begin
        fifo_cnt_m--;
        busy_m = 1'b1;
      end else if (last_flag) begin
        busy_m = 1'b0;
        last_flag = 1'b0;
      end
      sr_m = cap;
      if (cap) begin
        found_cnt_m = found_cnt_m + 16'd1;
        if (full_b) begin
          if (drop_m != 8'hFF) drop_m = drop_m + 8'd1;
        end else begin
          fifo_cnt_m++;
          exp_q.push_back(FRAME_HDR);
          for (int i = NT - 1; i >= 0; i--) exp_q.push_back(co_buf[i*8 +: 8]);
        end
      end
    end
  end

  // Monitor: per-cycle counters/pulse, byte scoreboard, hold-under-stall.
  initial forever begin
    int pos;
    bit stall;
    logic [7:0] hold_d;
    logic [7:0] e;
    @(negedge clk);
    if (res) begin
      pos = 0;
      stall = 1'b0;
    end else begin
      chk("search_res", 32'(search_res), 32'(sr_m));
      chk("found_cnt", 32'(found_cnt), 32'(found_cnt_m));
      chk("drop_cnt", 32'(drop_cnt), 32'(drop_m));
      if (stall) begin
        chk("stall_valid", 32'(dout_valid), 32'd1);
        chk("stall_dout", 32'(dout), 32'(hold_d));
      end
      if (dout_valid && dout_ready) begin
        acc_total++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(dout), 32'h1FF);
        end else begin
          e = exp_q.pop_front();
          chk("frame_byte", 32'(dout), 32'(e));
        end
        pos++;
        if (pos == NT + 1) begin
          pos = 0;
          last_flag = 1'b1;
        end
      end
      stall = dout_valid && !dout_ready;
      hold_d = dout;
    end
  end

  // Ready driver: 0 = hold low, 1 = hold high, 2 = toggle, else random.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: dout_ready = 1'b0;
      1: dout_ready = 1'b1;
      2: dout_ready = ~dout_ready;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    int base;
    int n;
    logic [15:0] fc_before;

    tick(3);
    chk("rst_search_res", 32'(search_res), 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_found_cnt", 32'(found_cnt), 32'd0);
    res = 1'b0;
    started = 1'b1;
    tick(2);

    // single capture with exact latency
    co_buf = 48'h0102_0304_0506;
    found = 1'b1;
    tick(1);
    chk("lat_sr_high", 32'(search_res), 32'd1);
    chk("lat_valid_n1", 32'(dout_valid), 32'd0);
    found = 1'b0;
    tick(1);
    chk("lat_sr_low", 32'(search_res), 32'd0);
    chk("lat_valid_n2", 32'(dout_valid), 32'd1);
    chk("lat_header", 32'(dout), 32'hA5);
    drain(200);
    chk("single_found_cnt", 32'(found_cnt), 32'd1);

    // held found: one capture only
    capture(rand_taps(), 20);
    drain(200);
    chk("held_found_cnt", 32'(found_cnt), 32'd2);

    // backpressure toggling
    ready_mode = 2;
    capture(rand_taps(), 1);
    tick(30);
    drain(200);

    // gating by started
    fc_before = found_cnt_m;
    started = 1'b0;
    capture(rand_taps(), 1);
    tick(3);
    chk("gated_found_cnt", 32'(found_cnt), 32'(fc_before));
    chk("gated_valid", 32'(dout_valid), 32'd0);
    started = 1'b1;

    // overflow: one frame stalled in the serializer, then 10 captures
    ready_mode = 0;
    tick(2);
    fc_before = found_cnt_m;
    capture(48'hAAAA_0000_0001, 1);
    tick(2);
    for (int i = 0; i < 10; i++) capture({8'hC0, 8'(i), 32'h1234_5678 + 32'(i)}, 1);
    tick(2);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("ovf_found_cnt", 32'(found_cnt), 32'(fc_before + 16'd11));
    drain(500);

    // reset mid-frame, with a second entry queued behind it
    ready_mode = 1;
    base = acc_total;
    capture(rand_taps(), 1);
    capture(rand_taps(), 1);
    n = 0;
    while (acc_total < base + 3 && n < 50) begin
      tick(1);
      n++;
    end
    chk("midres_wait", 32'(n < 50), 32'd1);
    res = 1'b1;
    tick(1);
    chk("midres_valid", 32'(dout_valid), 32'd0);
    chk("midres_found_cnt", 32'(found_cnt), 32'd0);
    chk("midres_drop_cnt", 32'(drop_cnt), 32'd0);
    res = 1'b0;
    tick(15);
    chk("midres_flushed", 32'(dout_valid), 32'd0);
    capture(rand_taps(), 1);
    drain(200);

    // randomized bursts
    for (int it = 0; it < 20; it++) begin
      ready_mode = $urandom_range(0, 3);
      n = $urandom_range(1, 11);
      for (int k = 0; k < n; k++) begin
        started = ($urandom_range(0, 3) != 0);
        capture(rand_taps(), $urandom_range(1, 3));
        tick($urandom_range(0, 3));
      end
      started = 1'b1;
      if ($urandom_range(0, 1) == 1) drain(1000);
    end
    drain(2000);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
